// File: rtl/hamming32t26d_chk.sv
// SEC-DED (32,26) checker: two-stage pipeline with valid/ready handshakes,
// single-error correction, double-error detection and saturating error counters.
module hamming32t26d_chk #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [31:0]          hv_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [25:0]          data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 sec_o,
  output logic                 ded_o,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] sec_cnt_o,
  output logic [CNT_WIDTH-1:0] ded_cnt_o,
  output logic                 ded_sticky_o
);

  localparam int unsigned HV_W   = 32;
  localparam int unsigned DATA_W = 26;
  localparam int unsigned SYN_W  = 5;

  // Syndrome bit k covers every position whose index has bit k set.
  function automatic logic [SYN_W-1:0] calc_syn(input logic [HV_W-1:0] hv);
    logic [SYN_W-1:0] s;
    s = '0;
    for (int unsigned i = 1; i < HV_W; i++) begin
      for (int unsigned k = 0; k < SYN_W; k++) begin
        if (((i >> k) & 32'd1) != 32'd0) s[3'(k)] = s[3'(k)] ^ hv[5'(i)];
      end
    end
    return s;
  endfunction

  // Gather the non-power-of-two positions (3,5,6,7,9..) in ascending order.
  function automatic logic [DATA_W-1:0] extract(input logic [HV_W-1:0] v);
    logic [DATA_W-1:0] d;
    int unsigned       j;
    d = '0;
    j = 0;
    for (int unsigned i = 3; i < HV_W; i++) begin
      if ((i & (i - 32'd1)) != 32'd0) begin
        d[5'(j)] = v[5'(i)];
        j++;
      end
    end
    return d;
  endfunction

  logic                 s1_valid_q, s1_valid_d;
  logic [HV_W-1:0]      s1_hv_q, s1_hv_d;
  logic [SYN_W-1:0]     s1_syn_q, s1_syn_d;
  logic                 s1_par_q, s1_par_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 sec_q, sec_d;
  logic                 ded_q, ded_d;
  logic [CNT_WIDTH-1:0] sec_cnt_q, sec_cnt_d;
  logic [CNT_WIDTH-1:0] ded_cnt_q, ded_cnt_d;
  logic                 sticky_q, sticky_d;

  logic                 s2_ready_c;
  logic                 out_hs_c;
  logic                 sec_ev_c;
  logic                 ded_ev_c;
  logic [HV_W-1:0]      corr_c;

  // Next-state: pipeline advance, correction, counters and sticky flag.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_hv_d    = s1_hv_q;
    s1_syn_d   = s1_syn_q;
    s1_par_d   = s1_par_q;
    s2_valid_d = s2_valid_q;
    data_d     = data_q;
    sec_d      = sec_q;
    ded_d      = ded_q;
    sec_cnt_d  = sec_cnt_q;
    ded_cnt_d  = ded_cnt_q;
    sticky_d   = sticky_q;

    s2_ready_c = !s2_valid_q || ready_i;
    ready_o    = !s1_valid_q || s2_ready_c;
    out_hs_c   = s2_valid_q && ready_i;
    sec_ev_c   = out_hs_c && sec_q;
    ded_ev_c   = out_hs_c && ded_q;

    // A set overall parity means one flipped bit at position s (s==0 is bit 0).
    corr_c = s1_par_q ? (s1_hv_q ^ (HV_W'(1) << s1_syn_q)) : s1_hv_q;

    if (ready_o) begin
      s1_valid_d = valid_i;
      if (valid_i) begin
        s1_hv_d  = hv_i;
        s1_syn_d = calc_syn(hv_i);
        s1_par_d = ^hv_i;
      end
    end

    if (s2_ready_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        data_d = extract(corr_c);
        sec_d  = s1_par_q;
        ded_d  = !s1_par_q && (s1_syn_q != '0);
      end
    end

    // An error event coinciding with a clear leaves the count at one.
    if (clr_i) begin
      sec_cnt_d = sec_ev_c ? CNT_WIDTH'(1) : '0;
      ded_cnt_d = ded_ev_c ? CNT_WIDTH'(1) : '0;
      sticky_d  = ded_ev_c;
    end else begin
      if (sec_ev_c && (sec_cnt_q != '1)) sec_cnt_d = sec_cnt_q + CNT_WIDTH'(1);
      if (ded_ev_c && (ded_cnt_q != '1)) ded_cnt_d = ded_cnt_q + CNT_WIDTH'(1);
      sticky_d = sticky_q || ded_ev_c;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s1_valid_q <= 1'b0;
      s1_hv_q    <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      data_q     <= '0;
      sec_q      <= 1'b0;
      ded_q      <= 1'b0;
      sec_cnt_q  <= '0;
      ded_cnt_q  <= '0;
      sticky_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_hv_q    <= s1_hv_d;
      s1_syn_q   <= s1_syn_d;
      s1_par_q   <= s1_par_d;
      s2_valid_q <= s2_valid_d;
      data_q     <= data_d;
      sec_q      <= sec_d;
      ded_q      <= ded_d;
      sec_cnt_q  <= sec_cnt_d;
      ded_cnt_q  <= ded_cnt_d;
      sticky_q   <= sticky_d;
    end
  end

  assign valid_o      = s2_valid_q;
  assign data_o       = data_q;
  assign sec_o        = sec_q;
  assign ded_o        = ded_q;
  assign sec_cnt_o    = sec_cnt_q;
  assign ded_cnt_o    = ded_cnt_q;
  assign ded_sticky_o = sticky_q;

endmodule

// File: tb/tb_hamming32t26d_chk.sv
// Directed bench for hamming32t26d_chk with a decoding model and a per-cycle scoreboard.
module tb_hamming32t26d_chk;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic [31:0]   hv_i;
  logic          valid_i;
  logic          ready_o;
  logic [25:0]   data_o;
  logic          valid_o;
  logic          ready_i;
  logic          sec_o;
  logic          ded_o;
  logic          clr_i;
  logic [CW-1:0] sec_cnt_o;
  logic [CW-1:0] ded_cnt_o;
  logic          ded_sticky_o;

  hamming32t26d_chk #(.CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .hv_i(hv_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .sec_o(sec_o), .ded_o(ded_o), .clr_i(clr_i), .sec_cnt_o(sec_cnt_o),
    .ded_cnt_o(ded_cnt_o), .ded_sticky_o(ded_sticky_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  int acc_cnt = 0;
  logic [27:0] exp_q[$];
  int m_sec = 0, m_ded = 0;
  logic m_sticky = 1'b0;
  logic prev_stall = 1'b0;
  logic [27:0] prev_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model decode: syndrome is the XOR of indices of set bits; returns {ded, sec, data}.
  function automatic logic [27:0] model_dec(input logic [31:0] hv);
    int s, p, n;
    logic [31:0] c;
    logic [25:0] d;
    s = 0; p = 0; n = 0; d = '0;
    for (int i = 0; i < 32; i++) if (hv[i]) begin s ^= i; p ^= 1; end
    c = hv;
    if (p == 1) c[s] = ~c[s];
    for (int i = 1; i < 32; i++) if ($countones(i) != 1) begin d[n] = c[i]; n++; end
    return {(p == 0 && s != 0), (p == 1), d};
  endfunction

  // Model encode: place data, set check bits to zero the syndrome, then overall parity.
  function automatic logic [31:0] encode(input logic [25:0] d);
    logic [31:0] v;
    int n, s;
    v = '0; n = 0; s = 0;
    for (int i = 1; i < 32; i++) if ($countones(i) != 1) begin v[i] = d[n]; n++; end
    for (int i = 1; i < 32; i++) if (v[i]) s ^= i;
    for (int k = 0; k < 5; k++) if (((s >> k) & 1) == 1) v[1 << k] = 1'b1;
    v[0] = ^v[31:1];
    return v;
  endfunction

  // Scoreboard and counter model, evaluated mid-cycle.
  always @(negedge clk_i) begin
    logic sev, dev;
    if (!rstn_i) begin
      exp_q.delete();
      m_sec = 0; m_ded = 0; m_sticky = 1'b0; prev_stall = 1'b0;
    end else begin
      chk("sec_cnt", 64'(sec_cnt_o), 64'(m_sec));
      chk("ded_cnt", 64'(ded_cnt_o), 64'(m_ded));
      chk("ded_sticky", 64'(ded_sticky_o), 64'(m_sticky));
      if (prev_stall) chk("stall_hold", 64'({valid_o, ded_o, sec_o, data_o}), 64'({1'b1, prev_out}));
      if (valid_o) chk("sec_ded_excl", 64'(sec_o & ded_o), 64'd0);
      sev = 1'b0; dev = 1'b0;
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'({ded_o, sec_o, data_o}), 64'hDEAD_0000_0000);
        end else begin
          logic [27:0] e;
          e = exp_q.pop_front();
          chk("out_word", 64'({ded_o, sec_o, data_o}), 64'(e));
          sev = e[26]; dev = e[27];
        end
      end
      if (clr_i) begin
        m_sec = sev ? 1 : 0; m_ded = dev ? 1 : 0; m_sticky = dev;
      end else begin
        if (sev && m_sec != CMAX) m_sec++;
        if (dev && m_ded != CMAX) m_ded++;
        m_sticky = m_sticky | dev;
      end
      if (valid_i && ready_o) begin
        exp_q.push_back(model_dec(hv_i));
        acc_cnt++;
      end
      prev_stall = valid_o && !ready_i;
      prev_out = {ded_o, sec_o, data_o};
    end
  end

  task automatic cyc();
    @(posedge clk_i); #1;
  endtask

  task automatic send(input logic [31:0] hv);
    logic acc, done;
    valid_i = 1'b1; hv_i = hv; done = 1'b0;
    for (int t = 0; t < 40; t++) begin
      acc = ready_o;
      cyc();
      if (acc) begin done = 1'b1; break; end
    end
    chk("send_accept", 64'(done), 64'd1);
  endtask

  task automatic drain();
    valid_i = 1'b0; ready_i = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (exp_q.size() == 0 && !valid_o) break;
      cyc();
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int a0;
    rstn_i = 1'b0; valid_i = 1'b0; hv_i = '0; ready_i = 1'b1; clr_i = 1'b0;
    repeat (3) cyc();
    chk("rst_outputs", 64'({valid_o, data_o, sec_o, ded_o, sec_cnt_o, ded_cnt_o, ded_sticky_o}), 64'd0);
    rstn_i = 1'b1;
    #1 chk("rst_ready", 64'(ready_o), 64'd1);

    // Hand-computed pins on the model itself.
    chk("pin_enc_ones", 64'(encode(26'h3FFFFFF)), 64'hFFFFFFFF);
    chk("pin_enc_one", 64'(encode(26'h1)), 64'hF);
    chk("pin_dec_zero", 64'(model_dec(32'h0)), 64'h0);
    chk("pin_dec_bit5", 64'(model_dec(32'hFFFFFFDF)), 64'h7FFFFFF);
    chk("pin_dec_par", 64'(model_dec(32'h1)), 64'h4000000);
    chk("pin_dec_28", 64'(model_dec(32'h28)), 64'h8000003);

    // Latency of two cycles with an all-zero word.
    send(32'h0);
    valid_i = 1'b0;
    chk("lat_c1_valid", 64'(valid_o), 64'd0);
    cyc();
    chk("lat_c2_word", 64'({valid_o, ded_o, sec_o, data_o}), 64'h1_0000_0000 >> 4);
    drain();

    // Back-to-back directed mix of clean, single and double errors.
    send(32'hFFFFFFDF);
    send(32'h1);
    send(32'h28);
    send(encode(26'h1234567) ^ (32'h1 << 17));
    send(encode(26'h0ABCDEF));
    send(encode(26'h2AAAAAA) ^ (32'h1 << 9) ^ (32'h1 << 20));
    send(encode(26'h1555555) ^ 32'h2);
    drain();
    chk("mix_sec_cnt", 64'(sec_cnt_o), 64'd4);
    chk("mix_ded_cnt", 64'(ded_cnt_o), 64'd2);
    chk("mix_sticky", 64'(ded_sticky_o), 64'd1);

    clr_i = 1'b1; cyc(); clr_i = 1'b0;
    chk("clr_state", 64'({sec_cnt_o, ded_cnt_o, ded_sticky_o}), 64'd0);

    // Backpressure: five offered words, only two fit.
    ready_i = 1'b0; a0 = acc_cnt;
    for (int i = 0; i < 5; i++) begin
      valid_i = 1'b1; hv_i = encode(26'(100 + i)); cyc();
    end
    chk("bp_accepted", 64'(acc_cnt - a0), 64'd2);
    chk("bp_ready", 64'(ready_o), 64'd0);
    drain();

    // Clear coinciding with a double-error handshake.
    ready_i = 1'b0;
    send(32'h28);
    valid_i = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (valid_o) break;
      cyc();
    end
    chk("clr_wait_valid", 64'(valid_o), 64'd1);
    ready_i = 1'b1; clr_i = 1'b1; cyc(); clr_i = 1'b0;
    chk("clr_ev_ded", 64'({ded_cnt_o, ded_sticky_o}), 64'({4'd1, 1'b1}));
    drain();

    // Saturation of the double-error counter.
    clr_i = 1'b1; cyc(); clr_i = 1'b0;
    for (int i = 0; i < 18; i++) send((i % 2 == 0) ? 32'h28 : 32'h6);
    drain();
    chk("sat_full", 64'(ded_cnt_o), 64'(CMAX));
    send(32'h28);
    drain();
    chk("sat_hold", 64'(ded_cnt_o), 64'(CMAX));

    // Reset with words in flight: none may appear afterwards.
    ready_i = 1'b0;
    send(encode(26'h5));
    send(encode(26'h6));
    valid_i = 1'b0;
    rstn_i = 1'b0;
    cyc();
    chk("midrst_valid", 64'({valid_o, ded_cnt_o}), 64'd0);
    rstn_i = 1'b1; ready_i = 1'b1;
    repeat (5) cyc();
    chk("midrst_quiet", 64'(valid_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
